seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment display driver.
// A bus write latches an 11-bit value, which a sequential double-dabble turns
// into BCD. The four digits are scanned onto active-low anode/segment lines.
// Optional leading-zero blanking is enabled by defining DISP_BLANK_EN.
module seg7_scan_driver #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [10:0] data_in,
  output logic [11:0] data_out
);

  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  conv_state_t conv_state;
  logic [3:0]  step_cnt;
  logic [26:0] shift_reg;
  logic [15:0] disp_bcd;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]  digit_idx;
  logic [3:0]  blank;
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [3:0]  cur_anode;

  // One double-dabble step: bump every BCD nibble >= 5 by 3, then shift left.
  function automatic logic [26:0] dabble_step(input logic [26:0] v);
    logic [26:0] t;
    t = v;
    for (int n = 0; n < 4; n++) begin
      if (t[11 + 4*n +: 4] >= 4'd5)
        t[11 + 4*n +: 4] = t[11 + 4*n +: 4] + 4'd3;
    end
    return {t[25:0], 1'b0};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for a BCD digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Converter: load on write (restarting any conversion), 11 shifts, then commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_state <= CONV_IDLE;
      step_cnt   <= 4'd0;
      shift_reg  <= 27'd0;
      disp_bcd   <= 16'd0;
    end else if (sel) begin
      conv_state <= CONV_SHIFT;
      step_cnt   <= 4'd0;
      shift_reg  <= {16'd0, data_in};
    end else begin
      case (conv_state)
        CONV_SHIFT: begin
          shift_reg <= dabble_step(shift_reg);
          if (step_cnt == 4'd10)
            conv_state <= CONV_DONE;
          else
            step_cnt <= step_cnt + 4'd1;
        end
        CONV_DONE: begin
          disp_bcd   <= shift_reg[26:11];
          conv_state <= CONV_IDLE;
        end
        default: conv_state <= CONV_IDLE;
      endcase
    end
  end

`ifdef DISP_BLANK_EN
  // Leading-zero blank flags, refreshed together with the displayed digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank <= 4'b1110;
    end else if (!sel && conv_state == CONV_DONE) begin
      blank[0] <= 1'b0;
      blank[3] <= (shift_reg[26:23] == 4'd0);
      blank[2] <= (shift_reg[26:19] == 8'd0);
      blank[1] <= (shift_reg[26:15] == 12'd0);
    end
  end
`else
  assign blank = 4'b0000;
`endif

  // Scan timer: each digit stays lit for REFRESH_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Pick the digit, blank flag and anode pattern for the current scan slot.
  always_comb begin
    cur_digit = disp_bcd[3:0];
    cur_blank = blank[0];
    cur_anode = 4'b1110;
    case (digit_idx)
      2'd1: begin cur_digit = disp_bcd[7:4];   cur_blank = blank[1]; cur_anode = 4'b1101; end
      2'd2: begin cur_digit = disp_bcd[11:8];  cur_blank = blank[2]; cur_anode = 4'b1011; end
      2'd3: begin cur_digit = disp_bcd[15:12]; cur_blank = blank[3]; cur_anode = 4'b0111; end
      default: ;
    endcase
  end

  // Registered display output; decimal point is always off.
  always_ff @(posedge clk) begin
    if (rst)
      data_out <= 12'hFFF;
    else
      data_out <= {cur_anode, 1'b1, (cur_blank ? 7'h7F : seg_code(cur_digit))};
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (REFRESH_CYCLES=4).
// Build with DISP_BLANK_EN defined to check leading-zero blanking.
module tb_seg7_scan_driver;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [10:0] data_in;
  logic [11:0] data_out;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];
  logic [6:0]  seg_tab[0:9];

  int m_cnt = 0;
  int m_idx = 0;
  int m_disp = 0;
  int m_pend = 0;
  int m_new = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_CYCLES(R)) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .data_in(data_in),
    .data_out(data_out)
  );

  // Expected output for the model's current scan slot and displayed value.
  function automatic logic [11:0] model_out();
    int div;
    int dig;
    logic blank_dig;
    logic [3:0] an;
    case (m_idx)
      1: begin div = 10;   an = 4'b1101; end
      2: begin div = 100;  an = 4'b1011; end
      3: begin div = 1000; an = 4'b0111; end
      default: begin div = 1; an = 4'b1110; end
    endcase
    dig = (m_disp / div) % 10;
    blank_dig = 1'b0;
`ifdef DISP_BLANK_EN
    if (m_idx == 3 && m_disp < 1000) blank_dig = 1'b1;
    if (m_idx == 2 && m_disp < 100)  blank_dig = 1'b1;
    if (m_idx == 1 && m_disp < 10)   blank_dig = 1'b1;
`endif
    return {an, 1'b1, (blank_dig ? 7'h7F : seg_tab[dig])};
  endfunction

  task automatic checkOutput();
    logic [11:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert (data_out === e) else begin
      miscompares++;
      $error("[TB] FAIL scan_vec%0d observed=%h expected=%h", vectors, data_out, e);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare.
  task automatic applyStimulus(input logic r, input logic s, input logic [10:0] d);
    rst = r;
    sel = s;
    data_in = d;
    @(posedge clk);
    if (r) begin
      exp_q.push_back(12'hFFF);
      m_cnt = 0; m_idx = 0; m_disp = 0; m_pend = 0;
    end else begin
      exp_q.push_back(model_out());
      if (s) begin
        m_pend = 12;
        m_new = int'(d);
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) m_disp = m_new;
      end
      if (m_cnt == R - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 11'd0);
  endtask

  task automatic checkLiteral(input string tag, input logic [11:0] e);
    vectors++;
    assert (data_out === e) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, data_out, e);
    end
  endtask

  // Step until the given anode is active (bounded), then compare the pattern.
  task automatic checkDigit(input string tag, input logic [11:0] e);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4 * R + 2 && !found; i++) begin
      if (data_out[11:8] === e[11:8]) found = 1'b1;
      else idle(1);
    end
    vectors++;
    assert (found && data_out === e) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, data_out, e);
    end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    rst = 1'b1; sel = 1'b0; data_in = 11'd0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 11'd0);
    applyStimulus(1'b1, 1'b0, 11'd0);
    checkLiteral("reset_all_off", 12'hFFF);
    idle(1);
    checkLiteral("first_digit0", 12'hEC0);
`ifdef DISP_BLANK_EN
    checkDigit("reset_d1", 12'hDFF);
    checkDigit("reset_d2", 12'hBFF);
    checkDigit("reset_d3", 12'h7FF);
`else
    checkDigit("reset_d1", 12'hDC0);
    checkDigit("reset_d2", 12'hBC0);
    checkDigit("reset_d3", 12'h7C0);
`endif

    $display("[TB] write 1234");
    applyStimulus(1'b0, 1'b1, 11'd1234);
    idle(20);
    checkDigit("w1234_d0", 12'hE99);
    checkDigit("w1234_d1", 12'hDB0);
    checkDigit("w1234_d2", 12'hBA4);
    checkDigit("w1234_d3", 12'h7F9);

    $display("[TB] write 2047");
    applyStimulus(1'b0, 1'b1, 11'd2047);
    idle(20);
    checkDigit("w2047_d0", 12'hEF8);
    checkDigit("w2047_d1", 12'hD99);
    checkDigit("w2047_d2", 12'hBC0);
    checkDigit("w2047_d3", 12'h7A4);

    $display("[TB] write 5 then 9");
    applyStimulus(1'b0, 1'b1, 11'd5);
    idle(1);
    applyStimulus(1'b0, 1'b1, 11'd9);
    idle(20);
    checkDigit("w9_d0", 12'hE90);

    $display("[TB] write 5");
    applyStimulus(1'b0, 1'b1, 11'd5);
    idle(20);
    checkDigit("w5_d0", 12'hE92);
`ifdef DISP_BLANK_EN
    checkDigit("w5_d1", 12'hDFF);
    checkDigit("w5_d2", 12'hBFF);
    checkDigit("w5_d3", 12'h7FF);
`else
    checkDigit("w5_d1", 12'hDC0);
    checkDigit("w5_d2", 12'hBC0);
    checkDigit("w5_d3", 12'h7C0);
`endif

    $display("[TB] sel held high");
    applyStimulus(1'b0, 1'b1, 11'd111);
    applyStimulus(1'b0, 1'b1, 11'd222);
    applyStimulus(1'b0, 1'b1, 11'd1987);
    idle(20);
    checkDigit("held_d3", 12'h7F9);

    $display("[TB] reset during conversion of 1000");
    applyStimulus(1'b0, 1'b1, 11'd1000);
    idle(5);
    applyStimulus(1'b1, 1'b0, 11'd0);
    checkLiteral("midconv_reset", 12'hFFF);
    idle(1);
    checkLiteral("after_reset_d0", 12'hEC0);
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
